// File: rtl/cdce_pkg.sv
// -----------------------------------------------------------------------------
// cdce_pkg
// Shared definitions for the CDCE configuration path (command shifter and
// serial readback receiver).
//   cdce_state_t : FSM state encoding. It is 3 bits wide so that it matches the
//                  command shifter.
//   CDCE_WORD_W  : native control-port word length.
//   CDCE_ADDR_W  : width of the register address field in bits [3:0].
// -----------------------------------------------------------------------------
package cdce_pkg;

    localparam int CDCE_WORD_W = 32;
    localparam int CDCE_ADDR_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3
    } cdce_state_t;

endpackage

// File: rtl/cdce_serial_in_if.sv
// -----------------------------------------------------------------------------
// cdce_serial_in_if
// Request/result bundle of the CDCE readback receiver.
//   enable, start_transaction, expected_addr : requester -> receiver
//   parallel_output, data_valid,
//   transaction_done, addr_error             : receiver -> requester
// Modports: master (requester side) and slave (receiver side).
// -----------------------------------------------------------------------------
interface cdce_serial_in_if #(
    parameter int WIDTH = cdce_pkg::CDCE_WORD_W
);
    import cdce_pkg::*;

    logic                   enable;
    logic                   start_transaction;
    logic [CDCE_ADDR_W-1:0] expected_addr;
    logic [WIDTH-1:0]       parallel_output;
    logic                   data_valid;
    logic                   transaction_done;
    logic                   addr_error;

    modport master (
        output enable,
        output start_transaction,
        output expected_addr,
        input  parallel_output,
        input  data_valid,
        input  transaction_done,
        input  addr_error
    );

    modport slave (
        input  enable,
        input  start_transaction,
        input  expected_addr,
        output parallel_output,
        output data_valid,
        output transaction_done,
        output addr_error
    );

endinterface

// File: rtl/cdce_shiftin_reg.sv
// -----------------------------------------------------------------------------
// cdce_shiftin_reg
// A WIDTH-bit serial-in, parallel-out shift register that shifts left with the
// new bit entering at the LSB.
// Ports:
//   clk, reset_n : clock, asynchronous active-low clear
//   shift_en     : shift din in on this rising edge
//   din          : serial input
//   word         : {stored bits, din}, which is the word including the bit
//                  currently on din
// Only WIDTH-1 bits are stored. The newest bit is taken straight from din, so
// on the final sampling edge `word` already holds the complete received word.
// -----------------------------------------------------------------------------
module cdce_shiftin_reg #(
    parameter int WIDTH = cdce_pkg::CDCE_WORD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-2:0] hist_q;

    assign word = {hist_q, din};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
        end else if (shift_en) begin
            hist_q <= word[WIDTH-2:0];
        end
    end

endmodule

// File: rtl/cdce_serial_in.sv
// -----------------------------------------------------------------------------
// cdce_serial_in
// CDCE control-port readback receiver. On an accepted start it drops cs_n,
// waits CAPTURE_DELAY cycles and then samples WIDTH bits MSB-first from miso.
// It then presents the word with a one-cycle data_valid pulse.
// Parameters:
//   WIDTH         : readback word length, 8..32
//   CAPTURE_DELAY : ARM cycles before the first sample, 1..15
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   miso          : serial data from the device
//   cs_n          : registered active-low chip select
//   bus (slave)   : enable, start_transaction, expected_addr in;
//                   parallel_output, data_valid, transaction_done, addr_error out
// Build option: CDCE_SERIAL_IN_ADDR_CHECK_EN adds the address check on
// bits [3:0]. Without this option, addr_error is tied to 0.
// -----------------------------------------------------------------------------
module cdce_serial_in
    import cdce_pkg::*;
#(
    parameter int WIDTH         = CDCE_WORD_W,
    parameter int CAPTURE_DELAY = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            miso,
    output logic            cs_n,
    cdce_serial_in_if.slave bus
);

    localparam int BIT_CNT_W = $clog2(WIDTH);
    localparam int ARM_CNT_W = 4;

    cdce_state_t          state_q;
    cdce_state_t          state_d;
    logic [ARM_CNT_W-1:0] arm_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic                 accept;
    logic                 shift_en;
    logic                 last_bit;
    logic [WIDTH-1:0]     rx_word;
    logic [WIDTH-1:0]     par_out_q;
    logic                 data_valid_q;
    logic                 done_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Once a transaction has left IDLE it always runs to DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_transaction && bus.enable) state_d = ARM;
            ARM:     if (arm_cnt_q == '0) state_d = SHIFT;
            SHIFT:   if (bit_cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        accept   = (state_q == IDLE) && bus.start_transaction && bus.enable;
        shift_en = (state_q == SHIFT);
        last_bit = (state_q == SHIFT) && (bit_cnt_q == '0);
    end

    // ARM delay counter and SHIFT bit counter. The bit counter is loaded on
    // the ARM->SHIFT edge, so that it reads WIDTH-1 during the first sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            if (accept) begin
                arm_cnt_q <= ARM_CNT_W'(CAPTURE_DELAY - 1);
            end else if ((state_q == ARM) && (arm_cnt_q != '0)) begin
                arm_cnt_q <= arm_cnt_q - ARM_CNT_W'(1);
            end

            if ((state_q == ARM) && (arm_cnt_q == '0)) begin
                bit_cnt_q <= BIT_CNT_W'(WIDTH - 1);
            end else if (shift_en && (bit_cnt_q != '0)) begin
                bit_cnt_q <= bit_cnt_q - BIT_CNT_W'(1);
            end
        end
    end

    cdce_shiftin_reg #(
        .WIDTH (WIDTH)
    ) u_shiftin (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (shift_en),
        .din      (miso),
        .word     (rx_word)
    );

    // Output registers. They are loaded on the edge that enters DONE, so the
    // word, data_valid and transaction_done are all visible during DONE.
    // cs_n follows the next state, so it is low in ARM and SHIFT and its reset
    // value takes effect immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_n         <= 1'b1;
            par_out_q    <= '0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            cs_n         <= !((state_d == ARM) || (state_d == SHIFT));
            data_valid_q <= last_bit;
            if (last_bit) begin
                par_out_q <= rx_word;
                done_q    <= 1'b1;
            end else if (accept) begin
                done_q    <= 1'b0;
            end
        end
    end

    assign bus.parallel_output  = par_out_q;
    assign bus.data_valid       = data_valid_q;
    assign bus.transaction_done = done_q;

`ifdef CDCE_SERIAL_IN_ADDR_CHECK_EN
    logic [CDCE_ADDR_W-1:0] exp_addr_q;
    logic                   addr_err_q;

    // The expected address is frozen at accept, so later changes on the input
    // cannot affect a transaction that is already in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_addr_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (accept) begin
                exp_addr_q <= bus.expected_addr;
            end
            if (last_bit) begin
                addr_err_q <= (rx_word[CDCE_ADDR_W-1:0] != exp_addr_q);
            end
        end
    end

    assign bus.addr_error = addr_err_q;
`else
    logic unused_expected_addr;
    assign unused_expected_addr = ^bus.expected_addr;
    assign bus.addr_error       = 1'b0;
`endif

endmodule
